// File: rtl/reg_file_seq_pkg.sv
// ============================================================================
// reg_file_seq_pkg
// Shared opcode, register-function, state and index constants.
// Revision: 1.0
// ============================================================================
`default_nettype none

package reg_file_seq_pkg;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LDEXT = 3'b001;
  localparam logic [2:0] OP_MOV   = 3'b010;
  localparam logic [2:0] OP_CLR   = 3'b011;
  localparam logic [2:0] OP_INC   = 3'b100;
  localparam logic [2:0] OP_DEC   = 3'b101;
  localparam logic [2:0] OP_SWAP  = 3'b110;
  localparam logic [2:0] OP_ILL   = 3'b111;

  localparam logic [2:0] FUN_DEC  = 3'b000;
  localparam logic [2:0] FUN_INC  = 3'b001;
  localparam logic [2:0] FUN_LOAD = 3'b010;
  localparam logic [2:0] FUN_CLR  = 3'b011;

  // S4 doubles as the SWAP scratch register.
  localparam logic [2:0] TEMP_IDX = 3'd7;

  // Index bit selecting the scratch bank (S1-S4) over the main bank (R1-R4).
  localparam int IDX_BANK_BIT = 2;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_EXEC = 3'd1;
  localparam state_t ST_STEP = 3'd2;
  localparam state_t ST_SW1  = 3'd3;
  localparam state_t ST_SW2  = 3'd4;
  localparam state_t ST_SW3  = 3'd5;
  localparam state_t ST_ERR  = 3'd6;

  typedef struct packed {
    logic [2:0] op;
    logic [2:0] dst;
    logic [2:0] src;
  } cmd_t;

  function automatic logic swap_uses_temp(input logic [2:0] dst, input logic [2:0] src);
    return (dst == TEMP_IDX) || (src == TEMP_IDX);
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file_sequencer_decode.sv
// ============================================================================
// reg_idx_decode
// Converts a register index plus enable into one-hot main/scratch write enables.
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_idx_decode
  import reg_file_seq_pkg::*;
(
  input  logic [2:0] i_idx,
  input  logic       i_en,
  output logic [3:0] o_reg_sel,
  output logic [3:0] o_scr_sel
);

  logic [3:0] w_onehot;

  // Lowest index in a bank maps to the most significant enable bit.
  always_comb begin
    w_onehot  = 4'b1000 >> i_idx[1:0];
    o_reg_sel = (i_en && !i_idx[IDX_BANK_BIT]) ? w_onehot : 4'b0000;
    o_scr_sel = (i_en &&  i_idx[IDX_BANK_BIT]) ? w_onehot : 4'b0000;
  end

endmodule

`default_nettype wire

// File: rtl/reg_file_sequencer.sv
// ============================================================================
// reg_file_sequencer
// Command sequencer driving register-file selects for load/move/step/swap ops.
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_file_sequencer
  import reg_file_seq_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic       CmdValid,
  output logic       CmdReady,
  input  logic [2:0] CmdOp,
  input  logic [2:0] CmdDst,
  input  logic [2:0] CmdSrc,
  input  logic [2:0] CmdCnt,
  output logic       Done,
  output logic       Err,
  output logic [2:0] OutASel,
  output logic [2:0] FunSel,
  output logic [3:0] RegSel,
  output logic [3:0] ScrSel,
  output logic       ISel
);

  state_t     r_state;
  state_t     w_state_nxt;
  cmd_t       r_cmd;
  cmd_t       w_cmd_in;
  logic [2:0] r_cnt;
  logic       w_accept;
  logic       w_wr_en;
  logic [2:0] w_wr_idx;

  assign CmdReady = (r_state == ST_IDLE);
  assign w_accept = CmdValid && CmdReady;

  always_comb begin
    w_cmd_in.op  = CmdOp;
    w_cmd_in.dst = CmdDst;
    w_cmd_in.src = CmdSrc;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          case (CmdOp)
            OP_INC, OP_DEC: w_state_nxt = ST_STEP;
            OP_SWAP: begin
              if (swap_uses_temp(CmdDst, CmdSrc)) begin
                w_state_nxt = ST_ERR;
              end else if (CmdDst == CmdSrc) begin
                w_state_nxt = ST_EXEC;
              end else begin
                w_state_nxt = ST_SW1;
              end
            end
            OP_ILL:  w_state_nxt = ST_ERR;
            default: w_state_nxt = ST_EXEC;
          endcase
        end
      end
      ST_STEP: begin
        if (r_cnt == 3'd0) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SW1:  w_state_nxt = ST_SW2;
      ST_SW2:  w_state_nxt = ST_SW3;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_cmd   <= '0;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cmd <= w_cmd_in;
        r_cnt <= CmdCnt;
      end else if ((r_state == ST_STEP) && (r_cnt != 3'd0)) begin
        r_cnt <= r_cnt - 3'd1;
      end
    end
  end

  always_comb begin
    w_wr_en  = 1'b0;
    w_wr_idx = 3'd0;
    OutASel  = 3'd0;
    FunSel   = FUN_LOAD;
    ISel     = 1'b0;
    Done     = 1'b0;
    Err      = 1'b0;
    case (r_state)
      ST_EXEC: begin
        Done = 1'b1;
        case (r_cmd.op)
          OP_LDEXT: begin
            w_wr_en  = 1'b1;
            w_wr_idx = r_cmd.dst;
          end
          OP_MOV: begin
            OutASel  = r_cmd.src;
            ISel     = 1'b1;
            w_wr_en  = 1'b1;
            w_wr_idx = r_cmd.dst;
          end
          OP_CLR: begin
            FunSel   = FUN_CLR;
            w_wr_en  = 1'b1;
            w_wr_idx = r_cmd.dst;
          end
          // NOP and a self-SWAP leave the file untouched.
          default: ;
        endcase
      end
      ST_STEP: begin
        FunSel   = (r_cmd.op == OP_INC) ? FUN_INC : FUN_DEC;
        w_wr_en  = 1'b1;
        w_wr_idx = r_cmd.dst;
        Done     = (r_cnt == 3'd0);
      end
      ST_SW1: begin
        OutASel  = r_cmd.dst;
        ISel     = 1'b1;
        w_wr_en  = 1'b1;
        w_wr_idx = TEMP_IDX;
      end
      ST_SW2: begin
        OutASel  = r_cmd.src;
        ISel     = 1'b1;
        w_wr_en  = 1'b1;
        w_wr_idx = r_cmd.dst;
      end
      ST_SW3: begin
        OutASel  = TEMP_IDX;
        ISel     = 1'b1;
        w_wr_en  = 1'b1;
        w_wr_idx = r_cmd.src;
        Done     = 1'b1;
      end
      ST_ERR: begin
        Done = 1'b1;
        Err  = 1'b1;
      end
      default: ;
    endcase
    // A command cut short by reset must not report completion.
    if (Reset) begin
      Done = 1'b0;
      Err  = 1'b0;
    end
  end

  reg_idx_decode u_decode (
    .i_idx     (w_wr_idx),
    .i_en      (w_wr_en && !Reset),
    .o_reg_sel (RegSel),
    .o_scr_sel (ScrSel)
  );

endmodule

`default_nettype wire

// File: tb/tb_reg_file_sequencer.sv
// ============================================================================
// tb_reg_file_sequencer
// Bench for reg_file_sequencer with a register-file model on its outputs.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_reg_file_sequencer;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       CmdValid;
  logic       CmdReady;
  logic [2:0] CmdOp, CmdDst, CmdSrc, CmdCnt;
  logic       Done, Err, ISel;
  logic [2:0] OutASel, FunSel;
  logic [3:0] RegSel, ScrSel;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] ext_bus;
  logic [7:0] rf     [8];
  logic [7:0] ref_rf [8];

  logic [3:0] tr_reg  [20];
  logic [3:0] tr_scr  [20];
  logic [2:0] tr_fun  [20];
  logic [2:0] tr_outa [20];
  logic       tr_isel [20];
  logic       tr_done [20];
  logic       tr_err  [20];
  int         tr_len;

  always #5 Clock = ~Clock;

  reg_file_sequencer dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .CmdValid (CmdValid),
    .CmdReady (CmdReady),
    .CmdOp    (CmdOp),
    .CmdDst   (CmdDst),
    .CmdSrc   (CmdSrc),
    .CmdCnt   (CmdCnt),
    .Done     (Done),
    .Err      (Err),
    .OutASel  (OutASel),
    .FunSel   (FunSel),
    .RegSel   (RegSel),
    .ScrSel   (ScrSel),
    .ISel     (ISel)
  );

  // Register file driven only by the sequencer's select outputs.
  int         w_idx;
  logic [7:0] w_data;

  always_comb begin
    w_idx = -1;
    for (int i = 0; i < 4; i++) begin
      if (RegSel[3-i]) w_idx = i;
      if (ScrSel[3-i]) w_idx = 4 + i;
    end
  end

  always_comb begin
    w_data = 8'h00;
    if (w_idx >= 0) begin
      case (FunSel)
        3'b000:  w_data = rf[w_idx[2:0]] - 8'd1;
        3'b001:  w_data = rf[w_idx[2:0]] + 8'd1;
        3'b010:  w_data = ISel ? rf[OutASel] : ext_bus;
        default: w_data = 8'h00;
      endcase
    end
  end

  always @(posedge Clock) begin
    if (w_idx >= 0) rf[w_idx[2:0]] <= w_data;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rf(input string tag);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_rf%0d", tag, i), {56'd0, rf[i]}, {56'd0, ref_rf[i]});
  endtask

  // Issue one command, trace every busy cycle, then check latency, error and file contents.
  task automatic do_cmd(input logic [2:0] op, input logic [2:0] dst,
                        input logic [2:0] src, input logic [2:0] cnt);
    int         exp_lat;
    logic       exp_err;
    int         n;
    logic [7:0] t;
    exp_err = (op == 3'd7) || ((op == 3'd6) && ((dst == 3'd7) || (src == 3'd7)));
    exp_lat = 1;
    if (!exp_err) begin
      case (op)
        3'd1: ref_rf[dst] = ext_bus;
        3'd2: ref_rf[dst] = ref_rf[src];
        3'd3: ref_rf[dst] = 8'h00;
        3'd4: begin ref_rf[dst] = ref_rf[dst] + {5'd0, cnt} + 8'd1; exp_lat = int'(cnt) + 1; end
        3'd5: begin ref_rf[dst] = ref_rf[dst] - {5'd0, cnt} - 8'd1; exp_lat = int'(cnt) + 1; end
        3'd6: if (dst != src) begin
          t = ref_rf[dst];
          ref_rf[dst] = ref_rf[src];
          ref_rf[src] = t;
          ref_rf[7]   = t;
          exp_lat     = 3;
        end
        default: ;
      endcase
    end
    chk("ready_before", {63'd0, CmdReady}, 64'd1);
    CmdValid = 1'b1;
    CmdOp = op; CmdDst = dst; CmdSrc = src; CmdCnt = cnt;
    @(posedge Clock); #1;
    CmdValid = 1'b0;
    CmdOp = 3'($urandom); CmdDst = 3'($urandom); CmdSrc = 3'($urandom); CmdCnt = 3'($urandom);
    n = 0;
    while (n < 20) begin
      tr_reg[n] = RegSel; tr_scr[n] = ScrSel; tr_fun[n] = FunSel; tr_outa[n] = OutASel;
      tr_isel[n] = ISel; tr_done[n] = Done; tr_err[n] = Err;
      chk("onehot", {63'd0, ($countones({RegSel, ScrSel}) <= 1)}, 64'd1);
      if (exp_err) chk("err_no_enable", {56'd0, RegSel, ScrSel}, 64'd0);
      n++;
      if (Done) break;
      // Requests while busy must be ignored.
      CmdValid = 1'($urandom);
      @(posedge Clock); #1;
    end
    CmdValid = 1'b0;
    tr_len = n;
    chk("latency", 64'(n), 64'(exp_lat));
    chk("err", {63'd0, Err}, {63'd0, exp_err});
    @(posedge Clock); #1;
    chk("ready_after", {63'd0, CmdReady}, 64'd1);
    chk("done_after", {63'd0, Done}, 64'd0);
    chk_rf("cmd");
  endtask

  initial begin
    logic [7:0] v0;
    Reset = 1'b1; CmdValid = 1'b0;
    CmdOp = 3'd0; CmdDst = 3'd0; CmdSrc = 3'd0; CmdCnt = 3'd0; ext_bus = 8'h00;
    repeat (3) @(posedge Clock);
    #1 Reset = 1'b0;
    #1;
    chk("rst_ready",  {63'd0, CmdReady}, 64'd1);
    chk("rst_done",   {63'd0, Done},     64'd0);
    chk("rst_err",    {63'd0, Err},      64'd0);
    chk("rst_regsel", {60'd0, RegSel},   64'd0);
    chk("rst_scrsel", {60'd0, ScrSel},   64'd0);
    chk("rst_outa",   {61'd0, OutASel},  64'd0);
    chk("rst_funsel", {61'd0, FunSel},   64'd2);
    chk("rst_isel",   {63'd0, ISel},     64'd0);
    @(posedge Clock); #1;

    for (int i = 0; i < 8; i++) begin
      ext_bus = 8'($urandom);
      do_cmd(3'd1, 3'(i), 3'd0, 3'd0);
    end

    // MOV R3 <- S2
    do_cmd(3'd2, 3'd2, 3'd5, 3'd0);
    chk("mov_outa",   {61'd0, tr_outa[0]}, 64'd5);
    chk("mov_isel",   {63'd0, tr_isel[0]}, 64'd1);
    chk("mov_funsel", {61'd0, tr_fun[0]},  64'd2);
    chk("mov_regsel", {60'd0, tr_reg[0]},  64'b0010);
    chk("mov_scrsel", {60'd0, tr_scr[0]},  64'd0);
    chk("mov_done",   {63'd0, tr_done[0]}, 64'd1);

    // INC R1 four times
    v0 = rf[0];
    do_cmd(3'd4, 3'd0, 3'd0, 3'd3);
    for (int i = 0; i < 4; i++) begin
      chk("inc_regsel", {60'd0, tr_reg[i]},  64'b1000);
      chk("inc_funsel", {61'd0, tr_fun[i]},  64'd1);
      chk("inc_done",   {63'd0, tr_done[i]}, {63'd0, (i == 3)});
    end
    chk("inc_r1", {56'd0, rf[0]}, {56'd0, v0 + 8'd4});

    do_cmd(3'd5, 3'd6, 3'd0, 3'd7);
    do_cmd(3'd5, 3'd3, 3'd0, 3'd0);
    do_cmd(3'd3, 3'd5, 3'd0, 3'd0);

    // SWAP R2 <-> S1 through S4
    ext_bus = 8'h0A; do_cmd(3'd1, 3'd1, 3'd0, 3'd0);
    ext_bus = 8'h0B; do_cmd(3'd1, 3'd4, 3'd0, 3'd0);
    do_cmd(3'd6, 3'd1, 3'd4, 3'd0);
    chk("swap1_scr", {60'd0, tr_scr[0]}, 64'b0001);
    chk("swap1_reg", {60'd0, tr_reg[0]}, 64'd0);
    chk("swap2_reg", {60'd0, tr_reg[1]}, 64'b0100);
    chk("swap2_scr", {60'd0, tr_scr[1]}, 64'd0);
    chk("swap3_scr", {60'd0, tr_scr[2]}, 64'b1000);
    chk("swap_r2",   {56'd0, rf[1]}, 64'h0B);
    chk("swap_s1",   {56'd0, rf[4]}, 64'h0A);

    do_cmd(3'd6, 3'd3, 3'd3, 3'd0);
    chk("selfswap_err", {63'd0, tr_err[0]}, 64'd0);
    do_cmd(3'd7, 3'd2, 3'd1, 3'd0);
    chk("ill_err",  {63'd0, tr_err[0]},  64'd1);
    chk("ill_done", {63'd0, tr_done[0]}, 64'd1);
    do_cmd(3'd6, 3'd7, 3'd2, 3'd0);
    chk("swap7_err", {63'd0, tr_err[0]}, 64'd1);

    // Reset in the middle of a SWAP: only the first (S4) write survives.
    ref_rf[7] = ref_rf[0];
    chk("abort_ready", {63'd0, CmdReady}, 64'd1);
    CmdValid = 1'b1; CmdOp = 3'd6; CmdDst = 3'd0; CmdSrc = 3'd5; CmdCnt = 3'd0;
    @(posedge Clock); #1;
    CmdValid = 1'b0;
    chk("abort_sw1_scr", {60'd0, ScrSel}, 64'b0001);
    @(posedge Clock); #1;
    chk("abort_sw2_reg", {60'd0, RegSel}, 64'b1000);
    Reset = 1'b1;
    #1;
    chk("abort_regsel", {60'd0, RegSel}, 64'd0);
    chk("abort_scrsel", {60'd0, ScrSel}, 64'd0);
    chk("abort_done",   {63'd0, Done},   64'd0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    #1;
    chk("abort_idle_ready", {63'd0, CmdReady}, 64'd1);
    chk("abort_idle_done",  {63'd0, Done},     64'd0);
    @(posedge Clock); #1;
    chk("abort_still_done", {63'd0, Done}, 64'd0);
    chk_rf("abort");

    for (int k = 0; k < 60; k++) begin
      ext_bus = 8'($urandom);
      do_cmd(3'($urandom_range(0, 7)), 3'($urandom), 3'($urandom), 3'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
